// File: rtl/io_timer_responder.sv
// io_timer_responder: 8-bit I/O-mapped timer with prescaler, overflow/compare flags and irq.
// Define TIMER_CTC_EN to add TCCR bit3 (WGM) clear-timer-on-compare mode.
module io_timer_responder #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 16'h0010
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    inout  wire  [DATA_WIDTH-1:0] bus_data,
    input  logic                  io_cs,
    input  logic                  io_we,
    input  logic                  io_oe,
    output logic                  irq
);
    logic [ADDR_WIDTH-1:0] off;
    logic [2:0] sel, cs;
    logic [7:0] wdata, tcnt, ocr, rdata;
    logic [9:0] pre_cnt, dm1;
    logic hit, wr, rd, run, tick, cmp, tov, ocf, toie, ocie, tov_set, ocf_set;
    logic wr_tccr, wr_tcnt, wr_ocr, wr_tifr, wr_timsk;
`ifdef TIMER_CTC_EN
    logic wgm;
`else
    logic wgm;
    assign wgm = 1'b0;
`endif
    // Offset wraps to a large value below BASE_ADDR, so one compare covers both bounds.
    assign off      = bus_addr - BASE_ADDR;
    assign hit      = io_cs && (off < ADDR_WIDTH'(5));
    assign sel      = off[2:0];
    assign wr       = hit && io_we;
    assign rd       = hit && io_oe && !io_we;
    assign wdata    = bus_data[7:0];
    assign wr_tccr  = wr && sel == 3'd0;
    assign wr_tcnt  = wr && sel == 3'd1;
    assign wr_ocr   = wr && sel == 3'd2;
    assign wr_tifr  = wr && sel == 3'd3;
    assign wr_timsk = wr && sel == 3'd4;
    always_comb begin
        run = cs >= 3'd1 && cs <= 3'd5;
        dm1 = cs == 3'd1 ? 10'd0 : cs == 3'd2 ? 10'd7 : cs == 3'd3 ? 10'd63 :
              cs == 3'd4 ? 10'd255 : 10'd1023;
        tick = run && pre_cnt == dm1;
        cmp = wgm ? tcnt == ocr : tcnt + 8'd1 == ocr;
        tov_set = tick && !wr_tcnt && !wgm && tcnt == 8'hFF;
        ocf_set = tick && !wr_tcnt && cmp;
        rdata = sel == 3'd0 ? {4'b0, wgm, cs} : sel == 3'd1 ? tcnt : sel == 3'd2 ? ocr :
                sel == 3'd3 ? {6'b0, ocf, tov} : {6'b0, ocie, toie};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
            cs      <= '0;
            tcnt    <= '0;
            ocr     <= '0;
            tov     <= 1'b0;
            ocf     <= 1'b0;
            toie    <= 1'b0;
            ocie    <= 1'b0;
`ifdef TIMER_CTC_EN
            wgm     <= 1'b0;
`endif
        end else begin
            pre_cnt <= (wr_tccr || !run || tick) ? '0 : pre_cnt + 10'd1;
            if (wr_tccr) cs <= wdata[2:0];
`ifdef TIMER_CTC_EN
            if (wr_tccr) wgm <= wdata[3];
`endif
            tcnt <= wr_tcnt ? wdata : tick ? ((wgm && tcnt == ocr) ? 8'd0 : tcnt + 8'd1) : tcnt;
            if (wr_ocr) ocr <= wdata;
            // A flag being set beats a same-cycle write-1-to-clear.
            tov <= tov_set || (tov && !(wr_tifr && wdata[0]));
            ocf <= ocf_set || (ocf && !(wr_tifr && wdata[1]));
            if (wr_timsk) {ocie, toie} <= wdata[1:0];
        end
    end
    assign irq      = (tov && toie) || (ocf && ocie);
    assign bus_data = rd ? DATA_WIDTH'(rdata) : 'z;
endmodule

// File: tb/tb_io_timer_responder.sv
// tb_io_timer_responder: table-driven register checks plus timed counter/flag sequences.
module tb_io_timer_responder;
    localparam logic [15:0] B = 16'h0010;
`ifdef TIMER_CTC_EN
    localparam bit CTC = 1'b1;
`else
    localparam bit CTC = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset, io_cs, io_we, io_oe, irq, drv_en;
    logic [15:0] bus_addr;
    logic [7:0] drv;
    tri1 [7:0] bus_data;
    assign bus_data = drv_en ? drv : 8'hzz;
    io_timer_responder dut (
        .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_data(bus_data),
        .io_cs(io_cs), .io_we(io_we), .io_oe(io_oe), .irq(irq)
    );
    always #5 clk = ~clk;
    typedef struct { logic [7:0] v; string n; } exp_t;
    typedef struct { logic [15:0] wa; logic [7:0] wd; logic [15:0] ra; logic [7:0] e; string n; } vec_t;
    exp_t sb[$];
    vec_t tv[10];
    int n_cmp = 0, n_bad = 0;
    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic idle();
        io_cs = 1'b0; io_we = 1'bx; io_oe = 1'bx; drv_en = 1'b0;
    endtask
    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_addr = a; drv = d; drv_en = 1'b1; io_cs = 1'b1; io_we = 1'b1; io_oe = 1'b0;
        @(posedge clk); #1;
        idle();
    endtask
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic rd(input logic [15:0] a, input logic [7:0] e, input string nm);
        exp_t x;
        sb.push_back('{e, nm});
        bus_addr = a; io_cs = 1'b1; io_we = 1'b0; io_oe = 1'b1; drv_en = 1'b0;
        #1;
        x = sb.pop_front();
        cmp(x.n, bus_data, x.v);
        idle();
    endtask
    task automatic chk_irq(input logic e, input string nm);
        cmp(nm, {7'b0, irq}, {7'b0, e});
    endtask
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        tv[0] = '{B+2, 8'hA5, B+2, 8'hA5, "ocr_rw"};
        tv[1] = '{B+4, 8'hFF, B+4, 8'h03, "timsk_mask"};
        tv[2] = '{B+1, 8'h3C, B+1, 8'h3C, "tcnt_rw"};
        tv[3] = '{B+3, 8'hFF, B+3, 8'h00, "tifr_w1c_idle"};
        tv[4] = '{B+0, 8'hF8, B+0, CTC ? 8'h08 : 8'h00, "tccr_mask"};
        tv[5] = '{B+0, 8'h06, B+1, 8'h3C, "cs6_tcnt"};
        tv[6] = '{B+0, 8'h07, B+0, 8'h07, "tccr_cs7"};
        tv[7] = '{B+5, 8'h77, B+2, 8'hA5, "above_range"};
        tv[8] = '{16'h000F, 8'h77, B+4, 8'h03, "below_range"};
        tv[9] = '{B+2, 8'h80, B+2, 8'h80, "ocr_rw2"};
        idle(); bus_addr = '0; drv = '0; reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_irq(1'b0, "irq_reset");
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            rd(B + 16'(i), 8'h00, "reset_val");
        end
        bus_addr = B+1; #1;
        cmp("z_idle", bus_data, 8'hFF);
        @(negedge clk);
        bus_addr = B+1; io_cs = 1'b0; io_we = 1'b1; io_oe = 1'b1; drv = 8'h55; drv_en = 1'b1;
        @(posedge clk); #1;
        idle();
        rd(B+1, 8'h00, "no_cs_write");
        for (int i = 0; i < 10; i++) begin
            wr(tv[i].wa, tv[i].wd);
            rd(tv[i].ra, tv[i].e, tv[i].n);
        end
        cyc(4);
        rd(B+1, 8'h3C, "cs7_stopped");
        rd(B+5, 8'hFF, "z_out_of_range");
        wr(B+0, 8'h00); wr(B+4, 8'h00);
        // Overflow: FE -> FF -> 00 with TOIE.
        wr(B+1, 8'hFE); wr(B+4, 8'h01); wr(B+0, 8'h01);
        rd(B+1, 8'hFE, "ovf_t0");
        cyc(1);
        rd(B+1, 8'hFF, "ovf_t1");
        chk_irq(1'b0, "ovf_irq_pre");
        cyc(1);
        rd(B+1, 8'h00, "ovf_t2");
        rd(B+3, 8'h01, "ovf_tov");
        chk_irq(1'b1, "ovf_irq");
        wr(B+0, 8'h00);
        wr(B+3, 8'h01);
        rd(B+3, 8'h00, "ovf_clr");
        chk_irq(1'b0, "ovf_irq_clr");
        // Prescaler /8 and restart on TCCR rewrite.
        wr(B+1, 8'h00); wr(B+0, 8'h02);
        cyc(7);
        rd(B+1, 8'h00, "div8_e7");
        cyc(1);
        rd(B+1, 8'h01, "div8_e8");
        cyc(3);
        wr(B+0, 8'h02);
        cyc(7);
        rd(B+1, 8'h01, "div8_restart_e7");
        cyc(1);
        rd(B+1, 8'h02, "div8_restart_e8");
        wr(B+0, 8'h00);
        // Compare match.
        wr(B+1, 8'h00); wr(B+2, 8'h05); wr(B+4, 8'h02); wr(B+3, 8'h03); wr(B+0, 8'h01);
        cyc(4);
        rd(B+1, 8'h04, "ocf_t4");
        rd(B+3, 8'h00, "ocf_pre");
        chk_irq(1'b0, "ocf_irq_pre");
        cyc(1);
        rd(B+1, 8'h05, "ocf_t5");
        rd(B+3, 8'h02, "ocf_set");
        chk_irq(1'b1, "ocf_irq");
        wr(B+0, 8'h00);
        wr(B+3, 8'h00);
        rd(B+3, 8'h02, "tifr_w0_keep");
        chk_irq(1'b1, "ocf_irq_keep");
        wr(B+3, 8'h02);
        rd(B+3, 8'h00, "ocf_clr");
        chk_irq(1'b0, "ocf_irq_clr");
        // TCNT write collides with a wrapping tick.
        wr(B+1, 8'hFF); wr(B+3, 8'h03); wr(B+0, 8'h01);
        wr(B+1, 8'h40);
        rd(B+1, 8'h40, "coll_tcnt");
        rd(B+3, 8'h00, "coll_no_flag");
        wr(B+0, 8'h00);
        // TOV clear collides with a wrap.
        wr(B+1, 8'hFE); wr(B+3, 8'h03); wr(B+0, 8'h01);
        cyc(1);
        wr(B+3, 8'h01);
        rd(B+3, 8'h01, "coll_tov_set_wins");
        rd(B+1, 8'h00, "coll_wrap");
        wr(B+0, 8'h00);
        rd(B+1, 8'h01, "stop_last_tick");
        wr(B+3, 8'h01);
        rd(B+3, 8'h00, "tov_clr");
        // CTC mode (free-run when the feature is absent).
        wr(B+1, 8'h00); wr(B+2, 8'h03); wr(B+3, 8'h03); wr(B+0, 8'h09);
        rd(B+0, CTC ? 8'h09 : 8'h01, "ctc_tccr");
        for (int i = 1; i <= 8; i++) begin
            cyc(1);
            rd(B+1, CTC ? 8'(i % 4) : 8'(i), "ctc_tcnt");
            if (i == 3) rd(B+3, CTC ? 8'h00 : 8'h02, "ctc_ocf_t3");
            if (i == 4) rd(B+3, 8'h02, "ctc_ocf_t4");
        end
        wr(B+0, 8'h00);
        // Reset overrides a concurrent write and clears irq.
        wr(B+3, 8'h03); wr(B+4, 8'h03); wr(B+1, 8'hFF); wr(B+0, 8'h01);
        cyc(1);
        chk_irq(1'b1, "pre_reset_irq");
        @(negedge clk);
        reset = 1'b1; bus_addr = B+1; drv = 8'h77; drv_en = 1'b1; io_cs = 1'b1; io_we = 1'b1; io_oe = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; idle();
        chk_irq(1'b0, "reset_irq");
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            rd(B + 16'(i), 8'h00, "reset2_val");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
